maxpool_2x2_stream: RTL

- Streaming 2x2, stride-2 max-pooling stage for YOLOv3-tiny layer 1. It sits directly downstream of the convolution/activation output.
- Consumes one feature-map pixel per cycle in raster order and emits one pooled pixel per 2x2 window.
- All comparisons are signed two's-complement max, using the same rule as the team's 2-input max comparator.
- Horizontal pairs are reduced on the fly; even-row partial maxima are held in a half-width line buffer.

---
 rtl/maxpool_2x2_stream.sv | 123 ++++++++++++
 1 files changed

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster-order pixel stream.
// Horizontal pairs reduce on the fly; even-row partial maxima wait in a half-width line buffer.
module maxpool_2x2_stream #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IMG_WIDTH  = 416,
  parameter int unsigned IMG_HEIGHT = 416
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int unsigned HalfW = IMG_WIDTH / 2;
  localparam int unsigned ColW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned LbW   = (HalfW > 1) ? $clog2(HalfW) : 1;

  if ((IMG_WIDTH % 2) != 0 || (IMG_HEIGHT % 2) != 0) begin : gen_dim_check
    $error("maxpool_2x2_stream: IMG_WIDTH and IMG_HEIGHT must both be even");
  end

  logic [ColW-1:0]       col_q, col_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [DATA_WIDTH-1:0] h_reg_q, h_reg_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic [DATA_WIDTH-1:0] line_buf [HalfW];

  logic                  in_fire;
  logic                  col_odd, row_odd, col_last, row_last;
  logic [LbW-1:0]        lb_idx;
  logic [DATA_WIDTH-1:0] hmax, pool;

  // a > b selects a, otherwise b.
  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // A held result blocks input, so a new load can never clobber an unaccepted one.
  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;

  assign col_odd  = col_q[0];
  assign row_odd  = row_q[0];
  assign col_last = (col_q == ColW'(IMG_WIDTH - 1));
  assign row_last = (row_q == RowW'(IMG_HEIGHT - 1));
  assign lb_idx   = LbW'(col_q >> 1);

  assign hmax = smax(h_reg_q, in_data);
  assign pool = smax(line_buf[lb_idx], hmax);

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    h_reg_d     = h_reg_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = '0;
    end

    if (in_fire) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end

      if (!col_odd) begin
        h_reg_d = in_data;
      end else if (row_odd) begin
        // Load wins over the clear of a simultaneous output transfer.
        out_data_d  = pool;
        out_valid_d = 1'b1;
        out_last_d  = row_last && col_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      h_reg_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      h_reg_q     <= h_reg_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Not reset: each entry is written in an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (in_fire && col_odd && !row_odd) begin
      line_buf[lb_idx] <= hmax;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
